riscv_test_monitor: RTL and testbench

- Synthesizable pass/fail monitor for riscv-tests (rv32ui/rv32um/...) runs on Core. It replaces per-test hard-coded end-PC checks.
- Watches the core PC, the gp register (x3) and data-memory writes. It decides pass, fail or timeout and reports the failing test number.
- Generalised over XLEN, end PC, tohost address, detection mode, hold depth and timeout. Sits beside Core in every test top; the bench only reads its outputs.

---
 rtl/riscv_test_monitor.sv | 111 +++++++++++
 tb/tb_riscv_test_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout monitor for riscv-tests runs: watches PC, gp (x3) and
// tohost writes, and latches a sticky verdict plus the failing test number.
module riscv_test_monitor #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  END_PC      = XLEN'('h44),
  parameter logic [XLEN-1:0]  TOHOST_ADDR = XLEN'('h1000),
  parameter int unsigned      MODE        = 2,
  parameter int unsigned      HOLD_CYCLES = 1,
  parameter int unsigned      TIMEOUT     = 5000,
  parameter int unsigned      CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  gp_i,
  input  logic             mem_we_i,
  input  logic [XLEN-1:0]  mem_addr_i,
  input  logic [XLEN-1:0]  mem_wdata_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  fail_num_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam int unsigned      HOLD_W       = 8;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               PC_EN        = (MODE == 0) || (MODE == 2);
  localparam bit               TH_EN        = (MODE == 1) || (MODE == 2);

  typedef enum logic {RUN, DONE} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              pc_hit_c;
  logic              pc_evt_c;
  logic              th_evt_c;
  logic              to_evt_c;

  // Event detection for the current cycle; MODE masks disabled sources.
  always_comb begin
    pc_hit_c = 1'b0;
    pc_evt_c = 1'b0;
    th_evt_c = 1'b0;
    to_evt_c = 1'b0;
    pc_hit_c = (pc_i == END_PC);
    pc_evt_c = PC_EN && pc_hit_c && (hold_cnt == HOLD_LAST);
    th_evt_c = TH_EN && mem_we_i && (mem_addr_i == TOHOST_ADDR) && mem_wdata_i[0];
    to_evt_c = (cycles_o == TIMEOUT_LAST);
  end

  // Verdict FSM; priority tohost > PC-match > timeout, restart suppresses detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      hold_cnt   <= '0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      timeout_o  <= 1'b0;
      fail_num_o <= '0;
      cycles_o   <= '0;
    end else if (restart) begin
      state      <= RUN;
      hold_cnt   <= '0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      timeout_o  <= 1'b0;
      fail_num_o <= '0;
      cycles_o   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cycles_o != '1) begin
            cycles_o <= cycles_o + CNT_W'(1);
          end
          if (!pc_hit_c) begin
            hold_cnt <= '0;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          if (th_evt_c) begin
            state      <= DONE;
            done_o     <= 1'b1;
            pass_o     <= (mem_wdata_i == XLEN'(1));
            fail_num_o <= mem_wdata_i >> 1;
          end else if (pc_evt_c) begin
            state      <= DONE;
            done_o     <= 1'b1;
            pass_o     <= (gp_i == XLEN'(1));
            fail_num_o <= gp_i >> 1;
          end else if (to_evt_c) begin
            state      <= DONE;
            done_o     <= 1'b1;
            timeout_o  <= 1'b1;
            pass_o     <= 1'b0;
            fail_num_o <= '0;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: four instances with different
// MODE/HOLD/TIMEOUT settings, verdicts and snapshots checked by one monitor.
module tb_riscv_test_monitor;

  typedef struct {
    int          inst;
    logic        done;
    logic        pass;
    logic        tmo;
    logic [31:0] fnum;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  restart;
  logic [31:0] pc    [4];
  logic [31:0] gp    [4];
  logic [3:0]  we;
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  done;
  logic [3:0]  pass;
  logic [3:0]  tmo;
  logic [31:0] fnum  [4];
  logic [31:0] cyc   [4];

  exp_t ver_q[$];
  exp_t snap_q[$];
  exp_t e_m;
  bit [3:0] prev = 4'b0;
  bit   finish_req = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // u0: MODE0 HOLD1, u1: MODE0 HOLD3, u2: MODE2 TIMEOUT20, u3: MODE1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    riscv_test_monitor #(
      .XLEN(32), .END_PC(32'h44), .TOHOST_ADDR(32'h1000),
      .MODE((g < 2) ? 0 : ((g == 2) ? 2 : 1)),
      .HOLD_CYCLES((g == 1) ? 3 : 1),
      .TIMEOUT((g == 2) ? 20 : 5000),
      .CNT_W(32)
    ) u_dut (
      .clk(clk), .rst(rst), .restart(restart[g]),
      .pc_i(pc[g]), .gp_i(gp[g]),
      .mem_we_i(we[g]), .mem_addr_i(addr[g]), .mem_wdata_i(wdata[g]),
      .done_o(done[g]), .pass_o(pass[g]), .timeout_o(tmo[g]),
      .fail_num_o(fnum[g]), .cycles_o(cyc[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int i, input logic d, input logic p, input logic t,
                      input logic [31:0] f, input logic [31:0] c);
    exp_t e;
    e.inst = i; e.done = d; e.pass = p; e.tmo = t; e.fnum = f; e.cyc = c;
    snap_q.push_back(e);
  endtask

  task automatic expect_v(input int i, input logic p, input logic t,
                          input logic [31:0] f, input logic [31:0] c);
    exp_t e;
    e.inst = i; e.done = 1'b1; e.pass = p; e.tmo = t; e.fnum = f; e.cyc = c;
    ver_q.push_back(e);
  endtask

  // Monitor: verdict on each done rise, then any queued snapshots.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done[i] && !prev[i]) begin
        checks++;
        if (ver_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_verdict u%0d: pass=%0b timeout=%0b fail_num=%0d cycles=%0d, no verdict expected",
                   i, pass[i], tmo[i], fnum[i], cyc[i]);
        end else begin
          e_m = ver_q.pop_front();
          if (e_m.inst != i || pass[i] !== e_m.pass || tmo[i] !== e_m.tmo ||
              fnum[i] !== e_m.fnum || cyc[i] !== e_m.cyc) begin
            errors++;
            $display("FAIL verdict u%0d: got pass=%0b timeout=%0b fail_num=%0d cycles=%0d, expected u%0d pass=%0b timeout=%0b fail_num=%0d cycles=%0d",
                     i, pass[i], tmo[i], fnum[i], cyc[i],
                     e_m.inst, e_m.pass, e_m.tmo, e_m.fnum, e_m.cyc);
          end
        end
      end
      prev[i] = done[i];
    end
    while (snap_q.size() > 0) begin
      e_m = snap_q.pop_front();
      checks++;
      if (done[e_m.inst] !== e_m.done || pass[e_m.inst] !== e_m.pass ||
          tmo[e_m.inst] !== e_m.tmo || fnum[e_m.inst] !== e_m.fnum ||
          cyc[e_m.inst] !== e_m.cyc) begin
        errors++;
        $display("FAIL snapshot u%0d @%0t: got done=%0b pass=%0b timeout=%0b fail_num=%0d cycles=%0d, expected done=%0b pass=%0b timeout=%0b fail_num=%0d cycles=%0d",
                 e_m.inst, $time, done[e_m.inst], pass[e_m.inst], tmo[e_m.inst],
                 fnum[e_m.inst], cyc[e_m.inst],
                 e_m.done, e_m.pass, e_m.tmo, e_m.fnum, e_m.cyc);
      end
    end
    if (finish_req) begin
      checks++;
      if (ver_q.size() != 0) begin
        errors++;
        $display("FAIL pending_verdicts: got %0d outstanding, expected 0", ver_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    restart = 4'b1111;
    we = 4'b0;
    for (int i = 0; i < 4; i++) begin
      pc[i] = '0; gp[i] = '0; addr[i] = '0; wdata[i] = '0;
    end
    #3;
    for (int i = 0; i < 4; i++) snap(i, 0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;

    // Test 1: MODE0 HOLD1 pass on first END_PC cycle, then frozen
    restart[0] = 1'b0; pc[0] = 32'h40; gp[0] = 32'd1;
    step();
    snap(0, 0, 0, 0, 0, 1);
    pc[0] = 32'h44;
    expect_v(0, 1, 0, 0, 2);
    step();
    pc[0] = 32'h0;
    step(); step();
    snap(0, 1, 1, 0, 0, 2);

    // Test 5a: restart from DONE, END_PC during restart cycle is ignored
    restart[0] = 1'b1; pc[0] = 32'h44;
    step();
    snap(0, 0, 0, 0, 0, 0);
    restart[0] = 1'b0;
    expect_v(0, 1, 0, 0, 1);
    step();
    pc[0] = 32'h0;
    step();

    // Test 2: MODE0 HOLD3, interrupted hold then full hold, gp=0x0B
    restart[1] = 1'b0; gp[1] = 32'h0B; pc[1] = 32'h44;
    step(); step();
    snap(1, 0, 0, 0, 0, 2);
    pc[1] = 32'h48;
    step();
    pc[1] = 32'h44;
    step(); step();
    snap(1, 0, 0, 0, 0, 5);
    expect_v(1, 0, 0, 5, 6);
    step();
    pc[1] = 32'h0;
    step();

    // Test 5b: async reset mid-hold clears everything, including u0 in DONE
    restart[1] = 1'b1;
    step();
    restart[1] = 1'b0; pc[1] = 32'h44;
    step(); step();
    #1;
    rst = 1'b1;
    restart[0] = 1'b1;
    snap(1, 0, 0, 0, 0, 0);
    snap(0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    step();
    snap(1, 0, 0, 0, 0, 1);
    restart[1] = 1'b1; pc[1] = 32'h0;
    step();

    // Test 3: MODE2 simultaneous tohost and END_PC, tohost wins
    restart[2] = 1'b0;
    we[2] = 1'b1; addr[2] = 32'h1000; wdata[2] = 32'h7; pc[2] = 32'h44; gp[2] = 32'd1;
    expect_v(2, 0, 0, 3, 1);
    step();
    we[2] = 1'b0; pc[2] = 32'h0; restart[2] = 1'b1;
    step();
    snap(2, 0, 0, 0, 0, 0);
    restart[2] = 1'b0;

    // Test 4: even tohost write ignored, then timeout at 20 cycles
    we[2] = 1'b1; addr[2] = 32'h1000; wdata[2] = 32'h2;
    step();
    we[2] = 1'b0;
    snap(2, 0, 0, 0, 0, 1);
    repeat (18) step();
    snap(2, 0, 0, 0, 0, 19);
    expect_v(2, 0, 1, 0, 20);
    step();
    step(); step();
    snap(2, 1, 0, 1, 0, 20);

    // Test 6: MODE1 ignores END_PC, wrong address ignored, tohost pass
    restart[3] = 1'b0; pc[3] = 32'h44; gp[3] = 32'd1;
    repeat (10) step();
    snap(3, 0, 0, 0, 0, 10);
    we[3] = 1'b1; addr[3] = 32'h1004; wdata[3] = 32'h1;
    step();
    snap(3, 0, 0, 0, 0, 11);
    addr[3] = 32'h1000;
    expect_v(3, 1, 0, 0, 12);
    step();
    we[3] = 1'b0;
    step();

    finish_req = 1'b1;
    repeat (10) step();
  end

endmodule
